// File: rtl/vga_scan_gen.sv
// vga_scan_gen: 640x480@60 style raster scan generator with a two-stage
// output pipeline (address stage, colour stage).
// Optional feature: define VGA_TEST_PATTERN_EN to add pat_sel, which replaces
// d_in with eight vertical 80-pixel colour bars.
module vga_scan_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [11:0] d_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        pat_sel,
`endif
  output logic [8:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic        rdn,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hs,
  output logic        vs,
  output logic        frame_start
);

  localparam logic [9:0] H_SYNC_END  = 10'd96;
  localparam logic [9:0] H_VIS_START = 10'd144;
  localparam logic [9:0] H_VIS_END   = 10'(144 + H_ACTIVE);
  localparam logic [9:0] H_LAST      = 10'(144 + H_ACTIVE + 16 - 1);
  localparam logic [9:0] V_SYNC_END  = 10'd2;
  localparam logic [9:0] V_VIS_START = 10'd35;
  localparam logic [9:0] V_VIS_END   = 10'(35 + V_ACTIVE);
  localparam logic [9:0] V_LAST      = 10'(35 + V_ACTIVE + 10 - 1);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [9:0]  col_addr_q, col_addr_d;
  logic [8:0]  row_addr_q, row_addr_d;
  logic        rdn_q, rdn_d;
  logic        fs_q, fs_d;
  logic        hs1_q, hs1_d;
  logic        vs1_q, vs1_d;
  logic        hs2_q, vs2_q;
  logic [11:0] rgb_q, rgb_d;
  logic [11:0] src_rgb;
  logic        vis;

  // Next counter values: h wraps every line, v advances and wraps on that same edge.
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Address stage inputs decoded from the counters.
  always_comb begin
    vis        = (h_cnt_q >= H_VIS_START) && (h_cnt_q < H_VIS_END) &&
                 (v_cnt_q >= V_VIS_START) && (v_cnt_q < V_VIS_END);
    col_addr_d = h_cnt_q - H_VIS_START;
    row_addr_d = v_cnt_q[8:0] - 9'd35;
    rdn_d      = ~vis;
    fs_d       = (h_cnt_q == H_VIS_START) && (v_cnt_q == V_VIS_START);
    hs1_d      = ~(h_cnt_q < H_SYNC_END);
    vs1_d      = ~(v_cnt_q < V_SYNC_END);
  end

  // Address stage registers; sync is carried along to stay aligned with colour.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      col_addr_q <= '0;
      row_addr_q <= '0;
      rdn_q      <= 1'b1;
      fs_q       <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
    end else begin
      col_addr_q <= col_addr_d;
      row_addr_q <= row_addr_d;
      rdn_q      <= rdn_d;
      fs_q       <= fs_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] bar_rgb;

  // Colour bar lookup from the address currently presented to the pixel source.
  always_comb begin
    bar_rgb = 12'h000;
    if      (col_addr_q < 10'd80)  bar_rgb = 12'hfff;
    else if (col_addr_q < 10'd160) bar_rgb = 12'hff0;
    else if (col_addr_q < 10'd240) bar_rgb = 12'h0ff;
    else if (col_addr_q < 10'd320) bar_rgb = 12'h0f0;
    else if (col_addr_q < 10'd400) bar_rgb = 12'hf0f;
    else if (col_addr_q < 10'd480) bar_rgb = 12'hf00;
    else if (col_addr_q < 10'd560) bar_rgb = 12'h00f;
    else                           bar_rgb = 12'h000;
  end
`endif

  // Colour stage input: pixel source (or bars), forced black outside the visible area.
  always_comb begin
    src_rgb = d_in;
`ifdef VGA_TEST_PATTERN_EN
    if (pat_sel) src_rgb = bar_rgb;
`endif
    rgb_d = rdn_q ? '0 : src_rgb;
  end

  // Colour stage registers with the second sync delay.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rgb_q <= '0;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  assign row_addr    = row_addr_q;
  assign col_addr    = col_addr_q;
  assign rdn         = rdn_q;
  assign frame_start = fs_q;
  assign r           = rgb_q[11:8];
  assign g           = rgb_q[7:4];
  assign b           = rgb_q[3:0];
  assign hs          = hs2_q;
  assign vs          = vs2_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a full-size instance and a small-geometry instance
// run side by side against a timing model computed from the absolute clock
// count since reset release.
module tb_vga_scan_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clrn;
  logic        pat_sel;
  logic [11:0] d_m, d_s;
  logic [8:0]  row_m, row_s;
  logic [9:0]  col_m, col_s;
  logic        rdn_m, rdn_s, hs_m, hs_s, vs_m, vs_s, fs_m, fs_s;
  logic [3:0]  r_m, g_m, b_m, r_s, g_s, b_s;

  int unsigned k;
  int unsigned mode_m, mode_s;
  logic [31:0] key;
  int unsigned n_chk, n_pass;
  int unsigned phase;
  int unsigned hs_low, vs_low, nz_pix, fs_cnt, fs_first;

  localparam int unsigned HA_S = 16;
  localparam int unsigned VA_S = 8;

  vga_scan_gen #(.H_ACTIVE(640), .V_ACTIVE(480)) u_dut (
    .clk(clk), .clrn(clrn), .d_in(d_m),
`ifdef VGA_TEST_PATTERN_EN
    .pat_sel(pat_sel),
`endif
    .row_addr(row_m), .col_addr(col_m), .rdn(rdn_m),
    .r(r_m), .g(g_m), .b(b_m), .hs(hs_m), .vs(vs_m), .frame_start(fs_m)
  );

  vga_scan_gen #(.H_ACTIVE(HA_S), .V_ACTIVE(VA_S)) u_small (
    .clk(clk), .clrn(clrn), .d_in(d_s),
`ifdef VGA_TEST_PATTERN_EN
    .pat_sel(pat_sel),
`endif
    .row_addr(row_s), .col_addr(col_s), .rdn(rdn_s),
    .r(r_s), .g(g_s), .b(b_s), .hs(hs_s), .vs(vs_s), .frame_start(fs_s)
  );

  // Pixel source: 0 constant, 1 address code, 2 keyed hash, 3 colour bars.
  function automatic logic [11:0] pix(int unsigned mode, logic [31:0] kk,
                                      logic [8:0] row, logic [9:0] col);
    logic [31:0] t;
    logic [11:0] bars [8];
    int unsigned idx;
    bars = '{12'hfff, 12'hff0, 12'h0ff, 12'h0f0, 12'hf0f, 12'hf00, 12'h00f, 12'h000};
    case (mode)
      0: return 12'hABC;
      1: return {col[3:0], row[3:0], 4'h5};
      2: begin
        t = kk ^ ({13'b0, row, col} * 32'h9E3779B1);
        return t[23:12];
      end
      default: begin
        idx = int'(col) / 80;
        if (idx > 7) idx = 7;
        return bars[idx];
      end
    endcase
  endfunction

  always_comb d_m = pix(mode_m, key, row_m, col_m);
  always_comb d_s = pix(mode_s, key, row_s, col_s);

  typedef struct {
    logic        rdn, fs, hs, vs;
    logic [9:0]  col;
    logic [8:0]  row;
    logic [11:0] rgb;
  } exp_t;

  // Expected outputs kk clocks after release, from raster position arithmetic.
  function automatic exp_t model(int unsigned hact, int unsigned vact, int unsigned kk,
                                 int unsigned mode, logic [31:0] kkey);
    exp_t e;
    int unsigned htot, vtot, p, h, v;
    logic [9:0] c2;
    logic [8:0] r2;
    htot = hact + 160;
    vtot = vact + 45;
    e.rdn = 1'b1; e.fs = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
    e.col = '0; e.row = '0; e.rgb = '0;
    if (kk >= 1) begin
      p = (kk - 1) % (htot * vtot);
      h = p % htot; v = p / htot;
      e.rdn = !(h >= 144 && h < 144 + hact && v >= 35 && v < 35 + vact);
      e.fs  = (h == 144 && v == 35);
      if (!e.rdn) begin
        e.col = 10'(h - 144);
        e.row = 9'(v - 35);
      end
    end
    if (kk >= 2) begin
      p = (kk - 2) % (htot * vtot);
      h = p % htot; v = p / htot;
      e.hs = !(h < 96);
      e.vs = !(v < 2);
      if (h >= 144 && h < 144 + hact && v >= 35 && v < 35 + vact) begin
        c2 = 10'(h - 144);
        r2 = 9'(v - 35);
        e.rgb = pix(mode, kkey, r2, c2);
      end
    end
    return e;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, req);
  endtask

  task automatic check_all();
    exp_t e;
    int unsigned em, es;
    em = pat_sel ? 3 : mode_m;
    es = pat_sel ? 3 : mode_s;
    e = model(640, 480, k, em, key);
    cmp("main", {rdn_m, fs_m, hs_m, vs_m, r_m, g_m, b_m}, {e.rdn, e.fs, e.hs, e.vs, e.rgb});
    if (!e.rdn || k == 0) cmp("main_addr", {row_m, col_m}, {e.row, e.col});
    e = model(HA_S, VA_S, k, es, key);
    cmp("small", {rdn_s, fs_s, hs_s, vs_s, r_s, g_s, b_s}, {e.rdn, e.fs, e.hs, e.vs, e.rgb});
    if (!e.rdn || k == 0) cmp("small_addr", {row_s, col_s}, {e.row, e.col});
    if (k >= 2 && k <= 801 && !hs_m) hs_low++;
    if (!vs_m) vs_low++;
    if ({r_m, g_m, b_m} != 12'h000) nz_pix++;
    if (fs_m) begin
      fs_cnt++;
      if (fs_first == 0) fs_first = k;
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until(input int unsigned target);
    while (k < target) step();
  endtask

  task automatic clear_stats();
    hs_low = 0; vs_low = 0; nz_pix = 0; fs_cnt = 0; fs_first = 0;
  endtask

  // Mid-frame reset: outputs must fall to reset values before any clock edge.
  task automatic mid_reset(input int unsigned hold);
    @(posedge clk);
    #3 clrn = 1'b0;
    #1;
    cmp("async_rst_m", {rdn_m, fs_m, hs_m, vs_m, r_m, g_m, b_m, row_m, col_m},
        {4'b1011, 12'h000, 9'd0, 10'd0});
    cmp("async_rst_s", {rdn_s, fs_s, hs_s, vs_s, r_s, g_s, b_s, row_s, col_s},
        {4'b1011, 12'h000, 9'd0, 10'd0});
    repeat (hold) @(posedge clk);
    @(negedge clk);
    cmp("rst_hold_m", {rdn_m, fs_m, hs_m, vs_m, r_m, g_m, b_m}, {4'b1011, 12'h000});
    clrn = 1'b1;
    k = 0;
    clear_stats();
    check_all();
  endtask

  typedef struct {
    int unsigned k;
    logic        rdn, fs, hs, vs;
    logic        chk_col;
    logic [9:0]  col;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0,   12'h000};
    vecs[1]  = '{1,     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0,   12'h000};
    vecs[2]  = '{2,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   12'h000};
    vecs[3]  = '{97,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   12'h000};
    vecs[4]  = '{98,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   12'h000};
    vecs[5]  = '{1601,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   12'h000};
    vecs[6]  = '{1602,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0,   12'h000};
    vecs[7]  = '{28145, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0,   12'h000};
    vecs[8]  = '{28146, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd1,   12'hABC};
    vecs[9]  = '{28784, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd639, 12'hABC};
    vecs[10] = '{28785, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0,   12'hABC};
    vecs[11] = '{28786, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0,   12'h000};

    n_chk = 0; n_pass = 0; k = 0; phase = 1;
    key = $urandom;
    mode_m = 0; mode_s = 2;
    pat_sel = 1'b0;
    clrn = 1'b0;
    clear_stats();
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    k = 0;
    check_all();

    // Constant colour, checkpoints from release through the first visible line.
    for (int i = 0; i < 12; i++) begin
      run_until(vecs[i].k);
      cmp("vec", {rdn_m, fs_m, hs_m, vs_m, r_m, g_m, b_m},
          {vecs[i].rdn, vecs[i].fs, vecs[i].hs, vecs[i].vs, vecs[i].rgb});
      if (vecs[i].chk_col) cmp("vec_col", {22'b0, col_m}, {22'b0, vecs[i].col});
    end
    run_until(29000);
    cmp("hs_low_per_line", hs_low, 96);
    cmp("vs_low_per_frame", vs_low, 1600);
    cmp("nonzero_pixels", nz_pix, 695);
    cmp("frame_start_count1", fs_cnt, 1);
    cmp("frame_start_at1", fs_first, 28145);

    // Abandon the frame mid-line and restart with the address-coded source.
    phase = 2;
    mode_m = 1;
    mid_reset($urandom_range(1, 5));
    run_until(28900);
`ifdef VGA_TEST_PATTERN_EN
    pat_sel = 1'b1;
    run_until(28946); cmp("bar_col0",   {r_m, g_m, b_m}, 12'hfff);
    run_until(29025); cmp("bar_col79",  {r_m, g_m, b_m}, 12'hfff);
    run_until(29026); cmp("bar_col80",  {r_m, g_m, b_m}, 12'hff0);
    run_until(29505); cmp("bar_col559", {r_m, g_m, b_m}, 12'h00f);
    run_until(29506); cmp("bar_col560", {r_m, g_m, b_m}, 12'h000);
    run_until(29585); cmp("bar_col639", {r_m, g_m, b_m}, 12'h000);
`endif
    run_until(29900);
    cmp("frame_start_count2", fs_cnt, 1);
    cmp("frame_start_at2", fs_first, 28145);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have port clk, input, 1 bit, pixel clock (25 MHz nominal); the only clock.
REQ-004 SHALL have port clrn, input, 1 bit, reset, asynchronous, active-low.
REQ-005 SHALL have port d_in, input, 12 bits, pixel colour {R[3:0],G[3:0],B[3:0]} returned by the pixel source for the current address.
REQ-006 SHALL have port row_addr, output, 9 bits, visible line index 0..479.
REQ-007 SHALL have port col_addr, output, 10 bits, visible pixel index 0..639.
REQ-008 SHALL have port rdn, output, 1 bit, low when row_addr/col_addr are inside the visible area.
REQ-009 SHALL have ports r, g, b, output, 4 bits each, pixel colour to the DAC.
REQ-010 SHALL have ports hs and vs, output, 1 bit each, sync pulses, active-low.
REQ-011 SHALL have port frame_start, output, 1 bit, one-cycle pulse at the first visible pixel of each frame.

Function
REQ-012 SHALL keep h_cnt 0..799 that increments every clk and wraps from 799 to 0.
REQ-013 SHALL keep v_cnt 0..524 that increments only when h_cnt wraps, and wraps from 524 to 0 on the same edge as the h_cnt wrap.
REQ-014 SHALL use horizontal timing: sync h_cnt 0..95, back porch 96..143, visible 144..783, front porch 784..799.
REQ-015 SHALL use vertical timing: sync v_cnt 0..1, back porch 2..34, visible 35..514, front porch 515..524.
REQ-016 SHALL register, one cycle after the counters: col_addr = h_cnt-144 and row_addr = v_cnt-35, truncated to port width; rdn = 0 only when both counters are visible.
REQ-017 SHALL leave col_addr and row_addr undefined-but-stable while rdn = 1; consumers ignore them.
REQ-018 SHALL sample d_in on the edge after row_addr/col_addr/rdn update; d_in is combinational from the address, so there is no handshake.
REQ-019 SHALL make r,g,b = d_in fields one cycle after the address when rdn was 0, and force them to 0 otherwise, so blanking is never violated.
REQ-020 SHALL delay hs and vs through two register stages so they align with r,g,b.
REQ-021 SHALL drive hs = 0 when h_cnt < 96 and vs = 0 when v_cnt < 2, at counter timing before the two-stage delay.
REQ-022 SHALL assert frame_start for exactly one cycle, aligned with rdn, when row_addr = 0 and col_addr = 0 go visible.
REQ-023 SHALL keep the period fixed at 800 clocks per line and 525 lines per frame, i.e. 420000 clocks per frame.

Reset
REQ-024 SHALL, while clrn = 0, immediately force h_cnt=0, v_cnt=0, row_addr=0, col_addr=0, rdn=1, r=g=b=0, hs=1, vs=1, frame_start=0.
REQ-025 SHALL, on clrn deassertion, start counting from h_cnt=0, v_cnt=0 on the next clk edge.
REQ-026 SHALL, when reset is asserted mid-frame, abandon the frame with no partial pulses after release.
REQ-027 SHALL emit the first frame_start 35*800+144+1 = 28145 clocks after the first post-reset edge.

Configuration
REQ-028 SHALL, when macro VGA_TEST_PATTERN_EN is defined, add input pat_sel (1 bit).
REQ-029 SHALL, when pat_sel = 1, ignore d_in and output eight vertical colour bars 80 pixels wide, in order fff, ff0, 0ff, 0f0, f0f, f00, 00f, 000, with the same latency and blanking.
REQ-030 SHALL, when VGA_TEST_PATTERN_EN is undefined, have no pat_sel port, and r,g,b always derive from d_in.

Verification
REQ-031 SHALL cover: release clrn and count clocks -> hs low 96 of every 800 clocks; vs low for 1600 clocks every 420000.
REQ-032 SHALL cover: d_in = 12'hABC constant -> r=A, g=B, b=C only in visible cycles; exactly 307200 non-zero pixels per frame; 0 during blanking.
REQ-033 SHALL cover: a bench model where d_in = {col_addr[3:0], row_addr[3:0], 4'h5} -> each output pixel matches the address issued exactly one cycle earlier.
REQ-034 SHALL cover: boundary checks -> col_addr 639 followed by rdn=1; row_addr 479 is the last visible line; v_cnt wraps on the same edge as h_cnt 799->0.
REQ-035 SHALL cover: clrn pulsed low at v_cnt=200 -> outputs hit reset values asynchronously; next frame_start arrives 28145 clocks after release.
REQ-036 SHALL cover: VGA_TEST_PATTERN_EN defined with pat_sel=1 -> col_addr 0..79 gives fff, 80..159 gives ff0, 560..639 gives 000.
